sw_wavefront_sched: RTL and testbench

//  Sequencer for the SW systolic PE array: sweeps the QUERY_LEN x REF_LEN score matrix in horizontal

---
 rtl/sw_pkg.sv | 37 +++
 rtl/sw_max_tracker.sv | 39 +++
 rtl/sw_wavefront_sched.sv | 164 ++++++++++++++++
 tb/tb_sw_wavefront_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman wavefront sequencer and its max tracker.
package sw_pkg;

    localparam int unsigned SW_REF_LEN         = 64;
    localparam int unsigned SW_QUERY_LEN       = 48;
    localparam int unsigned SW_NUM_PE          = 4;
    localparam int unsigned SW_WIDTH_SCORE     = 8;
    localparam int unsigned SW_WIDTH_POS_REF   = 7;
    localparam int unsigned SW_WIDTH_POS_QUERY = 6;

    localparam int SCORE_MATCH    = 2;
    localparam int SCORE_MISMATCH = -1;
    localparam int SCORE_G_OPEN   = 2;
    localparam int SCORE_G_EXTEND = 1;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        GAP,
        DONE
    } state_e;

    typedef struct packed {
        logic [SW_WIDTH_SCORE-1:0]     score;
        logic [SW_WIDTH_POS_QUERY-1:0] row;
        logic [SW_WIDTH_POS_REF-1:0]   col;
    } pos_t;

    // Higher score wins; ties go to the smaller row, then the smaller column.
    function automatic logic better(input pos_t a, input pos_t b);
        if (a.score != b.score) return a.score > b.score;
        if (a.row != b.row) return a.row < b.row;
        return a.col < b.col;
    endfunction

endpackage

// File: rtl/sw_max_tracker.sv
// Reduces the per-lane PE scores of one cycle and folds them into the running best cell.
module sw_max_tracker
    import sw_pkg::*;
#(
    parameter int unsigned NUM_PE = SW_NUM_PE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            update,
    input  logic [NUM_PE-1:0]               valid,
    input  logic [NUM_PE*SW_WIDTH_SCORE-1:0] h,
    input  logic [SW_WIDTH_POS_QUERY-1:0]   row_base,
    input  logic [SW_WIDTH_POS_REF-1:0]     col_base,
    output pos_t                            best
);

    pos_t best_q, best_d, cand;

    always_comb begin
        best_d = best_q;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_PE; k++) begin
            cand.score = h[k*SW_WIDTH_SCORE +: SW_WIDTH_SCORE];
            cand.row   = row_base + SW_WIDTH_POS_QUERY'(k + 1);
            cand.col   = col_base - SW_WIDTH_POS_REF'(k) + SW_WIDTH_POS_REF'(1);
            if (update && valid[k] && better(cand, best_d)) best_d = cand;
        end
        if (clear) best_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) best_q <= '0;
        else       best_q <= best_d;
    end

    assign best = best_q;

endmodule

// File: rtl/sw_wavefront_sched.sv
// Stripe/wavefront sequencer for the SW systolic array: skewed PE enables, buffer addressing, best cell.
module sw_wavefront_sched
    import sw_pkg::*;
#(
    parameter int unsigned REF_LEN         = SW_REF_LEN,
    parameter int unsigned QUERY_LEN       = SW_QUERY_LEN,
    parameter int unsigned NUM_PE          = SW_NUM_PE,
    parameter int unsigned WIDTH_SCORE     = SW_WIDTH_SCORE,
    parameter int unsigned WIDTH_POS_REF   = SW_WIDTH_POS_REF,
    parameter int unsigned WIDTH_POS_QUERY = SW_WIDTH_POS_QUERY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_PE-1:0]             pe_en,
    output logic                          q_load,
    output logic [WIDTH_POS_QUERY-1:0]    q_base,
    output logic [WIDTH_POS_REF-1:0]      ref_addr,
    output logic                          hb_rd_en,
    output logic [WIDTH_POS_REF-1:0]      hb_rd_addr,
    output logic                          hb_zero,
    output logic                          hb_wr_en,
    output logic [WIDTH_POS_REF-1:0]      hb_wr_addr,
    input  logic [NUM_PE*WIDTH_SCORE-1:0] pe_h,
    output logic [WIDTH_SCORE-1:0]        max,
    output logic [WIDTH_POS_REF-1:0]      pos_ref,
    output logic [WIDTH_POS_QUERY-1:0]    pos_query
);

    localparam int unsigned T_LAST      = REF_LEN + NUM_PE - 2;
    localparam int unsigned LAST_STRIPE = QUERY_LEN / NUM_PE - 1;

    state_e                     state_q, state_d;
    logic [WIDTH_POS_REF-1:0]   t_q, t_d;
    logic [WIDTH_POS_QUERY-1:0] stripe_q, stripe_d;
    logic                       busy_q, busy_d, done_q, done_d, q_load_q, q_load_d;
    logic                       hb_rd_en_q, hb_rd_en_d, hb_zero_q, hb_zero_d, hb_wr_en_q, hb_wr_en_d;
    logic [NUM_PE-1:0]          pe_en_q, pe_en_d, en_dly_q, en_dly_d;
    logic [WIDTH_POS_QUERY-1:0] q_base_q, q_base_d, qb_dly_q, qb_dly_d;
    logic [WIDTH_POS_REF-1:0]   ref_addr_q, ref_addr_d, t_dly_q, t_dly_d, hb_wr_addr_q, hb_wr_addr_d;
    logic                       run;
    int unsigned                t_i;
    pos_t                       best;

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        stripe_d = stripe_q;
        q_load_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d  = PRIME;
                stripe_d = '0;
                q_load_d = 1'b1;
            end
            PRIME: begin
                state_d = RUN;
                t_d     = '0;
            end
            RUN: if (t_q == WIDTH_POS_REF'(T_LAST)) begin
                state_d = GAP;
                t_d     = '0;
                if (stripe_q != WIDTH_POS_QUERY'(LAST_STRIPE)) begin
                    stripe_d = stripe_q + 1'b1;
                    q_load_d = 1'b1;
                end
            end else begin
                t_d = t_q + 1'b1;
            end
            // q_load is only raised in a non-final GAP, so it doubles as the "more stripes" flag.
            GAP:     state_d = q_load_q ? RUN : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        run    = (state_d == RUN);
        t_i    = 32'(t_d);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        for (int unsigned k = 0; k < NUM_PE; k++)
            pe_en_d[k] = run && (t_i >= k) && (t_i <= k + REF_LEN - 1);
        ref_addr_d = run ? t_d : '0;
        hb_rd_en_d = run && (t_i < REF_LEN);
        hb_zero_d  = run && (stripe_d == '0);
        q_base_d   = WIDTH_POS_QUERY'(32'(stripe_d) * NUM_PE);

        // PE results arrive one cycle after their enable; keep the context they belong to.
        en_dly_d     = pe_en_q;
        t_dly_d      = ref_addr_q;
        qb_dly_d     = q_base_q;
        hb_wr_en_d   = pe_en_q[NUM_PE-1];
        hb_wr_addr_d = pe_en_q[NUM_PE-1] ? ref_addr_q - WIDTH_POS_REF'(NUM_PE - 1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            t_q          <= '0;
            stripe_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            q_load_q     <= 1'b0;
            hb_rd_en_q   <= 1'b0;
            hb_zero_q    <= 1'b0;
            hb_wr_en_q   <= 1'b0;
            pe_en_q      <= '0;
            en_dly_q     <= '0;
            q_base_q     <= '0;
            qb_dly_q     <= '0;
            ref_addr_q   <= '0;
            t_dly_q      <= '0;
            hb_wr_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            stripe_q     <= stripe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            q_load_q     <= q_load_d;
            hb_rd_en_q   <= hb_rd_en_d;
            hb_zero_q    <= hb_zero_d;
            hb_wr_en_q   <= hb_wr_en_d;
            pe_en_q      <= pe_en_d;
            en_dly_q     <= en_dly_d;
            q_base_q     <= q_base_d;
            qb_dly_q     <= qb_dly_d;
            ref_addr_q   <= ref_addr_d;
            t_dly_q      <= t_dly_d;
            hb_wr_addr_q <= hb_wr_addr_d;
        end
    end

    sw_max_tracker #(
        .NUM_PE(NUM_PE)
    ) u_max (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == PRIME),
        .update  (busy_q),
        .valid   (en_dly_q),
        .h       (pe_h),
        .row_base(qb_dly_q),
        .col_base(t_dly_q),
        .best    (best)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign pe_en      = pe_en_q;
    assign q_load     = q_load_q;
    assign q_base     = q_base_q;
    assign ref_addr   = ref_addr_q;
    assign hb_rd_en   = hb_rd_en_q;
    assign hb_rd_addr = ref_addr_q;
    assign hb_zero    = hb_zero_q;
    assign hb_wr_en   = hb_wr_en_q;
    assign hb_wr_addr = hb_wr_addr_q;
    assign max        = best.score;
    assign pos_ref    = best.col;
    assign pos_query  = best.row;

endmodule

// File: tb/tb_sw_wavefront_sched.sv
// Directed bench for sw_wavefront_sched: cycle-exact output schedule plus planted-cell max tracking.
module tb_sw_wavefront_sched;

    logic        clk, reset, start;
    logic        busy, done, q_load, hb_rd_en, hb_zero, hb_wr_en;
    logic [3:0]  pe_en;
    logic [5:0]  q_base, pos_query;
    logic [6:0]  ref_addr, hb_rd_addr, hb_wr_addr, pos_ref;
    logic [31:0] pe_h;
    logic [7:0]  max;

    int n_tests = 0;
    int n_fail  = 0;

    int cell_r[$];
    int cell_c[$];
    int cell_s[$];

    sw_wavefront_sched dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pe_en     (pe_en),
        .q_load    (q_load),
        .q_base    (q_base),
        .ref_addr  (ref_addr),
        .hb_rd_en  (hb_rd_en),
        .hb_rd_addr(hb_rd_addr),
        .hb_zero   (hb_zero),
        .hb_wr_en  (hb_wr_en),
        .hb_wr_addr(hb_wr_addr),
        .pe_h      (pe_h),
        .max       (max),
        .pos_ref   (pos_ref),
        .pos_query (pos_query)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_outs();
        return {27'd0, busy, done, pe_en, q_load, q_base, ref_addr, hb_rd_en, hb_rd_addr,
                hb_zero, hb_wr_en, hb_wr_addr};
    endfunction

    // Expected outputs in cycle c after start (c=1 is PRIME, stripes of 67 RUN + 1 GAP, DONE at 818).
    function automatic logic [63:0] exp_outs(input int c);
        logic       b, d, ql, rden, zero, wren;
        logic [3:0] en;
        int         qb, ra, wa, s, t;
        b = 0; d = 0; ql = 0; rden = 0; zero = 0; wren = 0; en = '0;
        qb = 0; ra = 0; wa = 0;
        if (c == 1) begin
            b = 1; ql = 1;
        end else if (c >= 2 && c <= 817) begin
            s = (c - 2) / 68;
            t = (c - 2) % 68;
            b = 1;
            if (t <= 66) begin
                for (int k = 0; k < 4; k++) en[k] = (t >= k) && (t <= k + 63);
                ra = t; rden = (t < 64); zero = (s == 0); qb = s * 4;
                wren = (t >= 4); wa = wren ? t - 4 : 0;
            end else begin
                ql = (s < 11); qb = (s < 11) ? (s + 1) * 4 : 44;
                wren = 1; wa = 63;
            end
        end else if (c == 818) begin
            b = 1; d = 1; qb = 44;
        end else begin
            qb = 44;
        end
        return {27'd0, b, d, en, ql, 6'(qb), 7'(ra), rden, 7'(ra), zero, wren, 7'(wa)};
    endfunction

    // PE array model: lane k returns the planted score of cell (row, col) one cycle after its enable.
    initial begin
        logic [3:0]  en;
        int          tt, qb;
        logic [31:0] nxt;
        pe_h = '0;
        forever begin
            @(negedge clk);
            en = pe_en; tt = ref_addr; qb = q_base;
            @(posedge clk);
            #1;
            nxt = '0;
            for (int k = 0; k < 4; k++)
                if (en[k])
                    for (int i = 0; i < cell_r.size(); i++)
                        if (cell_r[i] == qb + k + 1 && cell_c[i] == tt - k + 1)
                            nxt[k*8 +: 8] = 8'(cell_s[i]);
            pe_h = nxt;
        end
    end

    task automatic set_cells(input int n, input int r[4], input int cc[4], input int sc[4]);
        cell_r.delete(); cell_c.delete(); cell_s.delete();
        for (int i = 0; i < n; i++) begin
            cell_r.push_back(r[i]); cell_c.push_back(cc[i]); cell_s.push_back(sc[i]);
        end
    endtask

    task automatic run_job(input string name, input int extra_start, input int abort_at,
                           input int exp_max, input int exp_r, input int exp_q);
        int dones = 0, done_cyc = -1, nql = 0, nzero = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 819; c++) begin
            start = (c == extra_start);
            reset = (c == abort_at);
            @(negedge clk);
            if (abort_at != 0 && c == abort_at + 1) begin
                check_eq({name, "_abort_outs"}, pack_outs(), 64'd0);
                check_eq({name, "_abort_max"}, {max, pos_query, pos_ref}, 64'd0);
                for (int i = 0; i < 850; i++) begin
                    @(negedge clk);
                    if (done) dones++;
                end
                check_eq({name, "_abort_nodone"}, 64'(dones), 64'd0);
                return;
            end
            check_eq($sformatf("%s_cyc%0d", name, c), pack_outs(), exp_outs(c));
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (q_load) nql++;
            if (hb_zero) nzero++;
            if (c == 818 || c == 819) begin
                check_eq($sformatf("%s_max_c%0d", name, c), 64'(max), 64'(exp_max));
                check_eq($sformatf("%s_posq_c%0d", name, c), 64'(pos_query), 64'(exp_q));
                check_eq($sformatf("%s_posr_c%0d", name, c), 64'(pos_ref), 64'(exp_r));
            end
            @(posedge clk); #1;
        end
        check_eq({name, "_done_count"}, 64'(dones), 64'd1);
        check_eq({name, "_done_cycle"}, 64'(done_cyc), 64'd818);
        check_eq({name, "_qload_count"}, 64'(nql), 64'd12);
        check_eq({name, "_hbzero_count"}, 64'(nzero), 64'd67);
    endtask

    initial begin
        int r[4], cc[4], sc[4];
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", pack_outs(), 64'd0);
        check_eq("reset_max", {max, pos_query, pos_ref}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        set_cells(0, r, cc, sc);
        run_job("zero", 0, 0, 0, 0, 0);

        r = '{11, 1, 12, 0}; cc = '{33, 1, 30, 0}; sc = '{20, 7, 20, 0};
        set_cells(3, r, cc, sc);
        run_job("single", 100, 0, 20, 33, 11);

        r = '{5, 6, 5, 30}; cc = '{12, 11, 40, 2}; sc = '{15, 15, 15, 15};
        set_cells(4, r, cc, sc);
        run_job("ties", 0, 0, 15, 12, 5);

        r = '{48, 1, 0, 0}; cc = '{64, 1, 0, 0}; sc = '{31, 30, 0, 0};
        set_cells(2, r, cc, sc);
        run_job("lastcell", 0, 0, 31, 64, 48);

        r = '{11, 1, 12, 0}; cc = '{33, 1, 30, 0}; sc = '{20, 7, 20, 0};
        set_cells(3, r, cc, sc);
        run_job("abort", 0, 370, 0, 0, 0);
        run_job("restart", 0, 0, 20, 33, 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
